// File: rtl/encoder8to3_irq_if.sv
// Request/issue bundle for the 8-to-3 priority encoder.
// master = encoder side (drives the issue slot), slave = requester/consumer side.
interface encoder8to3_irq_if;
  logic [7:0] req;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pend;
  logic       any;

  modport master (input req, ready, output code, valid, pend, any);
  modport slave  (output req, ready, input code, valid, pend, any);
endinterface

// File: rtl/encoder8to3_irq.sv
// Sequential 8-to-3 priority encoder: sticky pending flags feed a one-deep
// valid/ready issue slot; a flag is cleared only when its index enters the slot.
module encoder8to3_irq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  encoder8to3_irq_if.master bus
);

  logic [7:0] pend_q, pend_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;

  logic [2:0] sel;
  logic       pend_nz;
  logic       slot_free;
  logic [7:0] load_oh;

  assign pend_nz   = |pend_q;
  assign slot_free = !valid_q || bus.ready;

  // Later loop iterations override earlier ones, so scan direction sets priority.
  always_comb begin
    sel = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) sel = i[2:0];
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) sel = i[2:0];
      end
    end
  end

  always_comb begin
    load_oh = 8'h00;
    if (slot_free && pend_nz) load_oh = 8'h01 << sel;
  end

  always_comb begin
    pend_d  = (pend_q & ~load_oh) | bus.req;
    code_d  = code_q;
    valid_d = valid_q;
    if (slot_free) begin
      valid_d = pend_nz;
      if (pend_nz) code_d = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 8'h00;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.pend  = pend_q;
  assign bus.any   = pend_nz;

endmodule

// File: tb/tb_encoder8to3_irq.sv
// Directed bench for encoder8to3_irq: one instance per priority order, with a
// scoreboard of expected issued indices checked on each accepted handshake.
module tb_encoder8to3_irq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  encoder8to3_irq_if ifc_hi ();
  encoder8to3_irq_if ifc_lo ();

  encoder8to3_irq #(.HIGH_FIRST(1'b1)) u_hi (.clk(clk), .rst(rst), .bus(ifc_hi.master));
  encoder8to3_irq #(.HIGH_FIRST(1'b0)) u_lo (.clk(clk), .rst(rst), .bus(ifc_lo.master));

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] exp_hi[$];
  logic [2:0] exp_lo[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic rdy);
    ifc_hi.req = r;  ifc_hi.ready = rdy;
    ifc_lo.req = r;  ifc_lo.ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] h, input logic [2:0] l);
    exp_hi.push_back(h);
    exp_lo.push_back(l);
  endtask

  initial begin
    drive(8'h00, 1'b0);

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    fork
      forever begin
        @(negedge clk);
        if (!rst && ifc_hi.valid && ifc_hi.ready) begin
          if (exp_hi.size() == 0) check("hi_unexpected_issue", {5'd0, ifc_hi.code}, 8'hFF);
          else check("hi_issue", {5'd0, ifc_hi.code}, {5'd0, exp_hi.pop_front()});
        end
        if (!rst && ifc_lo.valid && ifc_lo.ready) begin
          if (exp_lo.size() == 0) check("lo_unexpected_issue", {5'd0, ifc_lo.code}, 8'hFF);
          else check("lo_issue", {5'd0, ifc_lo.code}, {5'd0, exp_lo.pop_front()});
        end
      end
    join_none

    // Reset state
    step(); step();
    check("rst_pend", ifc_hi.pend, 8'h00);
    check("rst_valid", {7'd0, ifc_hi.valid}, 8'h00);
    check("rst_code", {5'd0, ifc_hi.code}, 8'h00);
    check("rst_any", {7'd0, ifc_hi.any}, 8'h00);
    rst = 1'b0;

    // Single request, 2-edge latency
    step();
    push(3'd5, 3'd5);
    drive(8'h20, 1'b1);
    step();
    check("single_pend_N", ifc_hi.pend, 8'h20);
    check("single_valid_N", {7'd0, ifc_hi.valid}, 8'h00);
    check("single_any_N", {7'd0, ifc_hi.any}, 8'h01);
    drive(8'h00, 1'b1);
    step();
    check("single_code_N1", {5'd0, ifc_hi.code}, 8'h05);
    check("single_valid_N1", {7'd0, ifc_hi.valid}, 8'h01);
    check("single_pend_N1", ifc_hi.pend, 8'h00);
    step();
    check("single_valid_N2", {7'd0, ifc_hi.valid}, 8'h00);

    // Priority order in both directions
    push(3'd6, 3'd0);
    push(3'd3, 3'd3);
    push(3'd0, 3'd6);
    drive(8'h49, 1'b1);
    step();
    drive(8'h00, 1'b1);
    step();
    check("prio_hi_first", {5'd0, ifc_hi.code}, 8'h06);
    check("prio_lo_first", {5'd0, ifc_lo.code}, 8'h00);
    step(); step();
    step();
    check("prio_hi_done", {7'd0, ifc_hi.valid}, 8'h00);
    check("prio_lo_done", {7'd0, ifc_lo.valid}, 8'h00);

    // Backpressure
    drive(8'h02, 1'b0);
    step();
    drive(8'h80, 1'b0);
    step();
    drive(8'h00, 1'b0);
    check("bp_code", {5'd0, ifc_hi.code}, 8'h01);
    check("bp_valid", {7'd0, ifc_hi.valid}, 8'h01);
    check("bp_pend", ifc_hi.pend, 8'h80);
    step();
    check("bp_code_hold", {5'd0, ifc_hi.code}, 8'h01);
    check("bp_valid_hold", {7'd0, ifc_hi.valid}, 8'h01);
    check("bp_pend_hold", ifc_hi.pend, 8'h80);
    push(3'd1, 3'd1);
    push(3'd7, 3'd7);
    drive(8'h00, 1'b1);
    step();
    check("bp_next_code", {5'd0, ifc_hi.code}, 8'h07);
    check("bp_next_valid", {7'd0, ifc_hi.valid}, 8'h01);
    step();
    drive(8'h00, 1'b0);
    check("bp_empty_valid", {7'd0, ifc_hi.valid}, 8'h00);

    // Coalesce and re-post of the index held in the slot
    drive(8'h10, 1'b0);
    step();
    drive(8'h00, 1'b0);
    step();
    check("coal_slot_code", {5'd0, ifc_hi.code}, 8'h04);
    check("coal_slot_pend", ifc_hi.pend, 8'h00);
    for (int k = 0; k < 3; k++) begin
      drive(8'h10, 1'b0);
      step();
      drive(8'h00, 1'b0);
      step();
    end
    check("coal_pend", ifc_hi.pend, 8'h10);
    check("coal_code_hold", {5'd0, ifc_hi.code}, 8'h04);
    check("coal_valid_hold", {7'd0, ifc_hi.valid}, 8'h01);
    push(3'd4, 3'd4);
    push(3'd4, 3'd4);
    drive(8'h00, 1'b1);
    step();
    check("coal_reissue_pend", ifc_hi.pend, 8'h00);
    step();
    check("coal_done_valid", {7'd0, ifc_hi.valid}, 8'h00);

    // Simultaneous load and re-request
    drive(8'h08, 1'b1);
    step();
    check("sim_pend_pre", ifc_hi.pend, 8'h08);
    check("sim_valid_pre", {7'd0, ifc_hi.valid}, 8'h00);
    push(3'd3, 3'd3);
    push(3'd3, 3'd3);
    step();
    drive(8'h00, 1'b1);
    check("sim_code", {5'd0, ifc_hi.code}, 8'h03);
    check("sim_valid", {7'd0, ifc_hi.valid}, 8'h01);
    check("sim_pend", ifc_hi.pend, 8'h08);
    step();
    check("sim_pend_after", ifc_hi.pend, 8'h00);
    step();
    check("sim_done_valid", {7'd0, ifc_hi.valid}, 8'h00);

    // Asynchronous reset mid-cycle with work in flight
    drive(8'hA5, 1'b0);
    step(); step();
    check("pre_rst_pend", ifc_hi.pend, 8'hA5);
    check("pre_rst_valid", {7'd0, ifc_hi.valid}, 8'h01);
    check("pre_rst_code", {5'd0, ifc_hi.code}, 8'h07);
    #2;
    rst = 1'b1;
    drive(8'h00, 1'b0);
    #1;
    check("arst_pend", ifc_hi.pend, 8'h00);
    check("arst_valid", {7'd0, ifc_hi.valid}, 8'h00);
    check("arst_code", {5'd0, ifc_hi.code}, 8'h00);
    check("arst_any", {7'd0, ifc_hi.any}, 8'h00);
    check("arst_lo_pend", ifc_lo.pend, 8'h00);
    step();
    rst = 1'b0;
    step();
    check("post_rst1_valid", {7'd0, ifc_hi.valid}, 8'h00);
    check("post_rst1_pend", ifc_hi.pend, 8'h00);
    step();
    check("post_rst2_valid", {7'd0, ifc_hi.valid}, 8'h00);
    check("post_rst2_any", {7'd0, ifc_hi.any}, 8'h00);

    check("hi_queue_drained", 8'(exp_hi.size()), 8'h00);
    check("lo_queue_drained", 8'(exp_lo.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
